// File: rtl/interval_timer.sv
// interval_timer: counts qualified tick strobes up to a loadable period
// and pulses done_o once per period, in one-shot or periodic mode.
module interval_timer #(
  parameter int unsigned WORD_LENGTH    = 17,
  parameter int unsigned DEFAULT_PERIOD = 125000
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   mode_i,
  input  logic                   period_load_i,
  input  logic [WORD_LENGTH-1:0] period_i,
  input  logic                   tick_i,
  output logic                   done_o,
  output logic                   running_o,
  output logic                   paused_o,
  output logic [WORD_LENGTH-1:0] count_o
);

  localparam logic [WORD_LENGTH-1:0] DEF_PERIOD =
    WORD_LENGTH'(DEFAULT_PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t                 state_q;
  logic [WORD_LENGTH-1:0] count_q;
  logic [WORD_LENGTH-1:0] period_q;
  logic                   done_q;
  logic                   running_q;
  logic                   paused_q;

  logic [WORD_LENGTH:0]   count_inc;
  logic                   terminal;

  // One extra bit keeps count+1 exact; >= lets a shrunk period end early.
  assign count_inc = {1'b0, count_q} + {{WORD_LENGTH{1'b0}}, 1'b1};
  assign terminal  = count_inc >= {1'b0, period_q};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      period_q <= DEF_PERIOD;
    end else if (period_load_i && (period_i != '0)) begin
      period_q <= period_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_i) begin
        state_q   <= IDLE;
        count_q   <= '0;
        running_q <= 1'b0;
        paused_q  <= 1'b0;
      end else if (start_i) begin
        state_q   <= RUN;
        count_q   <= '0;
        running_q <= 1'b1;
        paused_q  <= 1'b0;
      end else begin
        unique case (state_q)
          RUN: begin
            if (!enable_i) begin
              state_q   <= HOLD;
              running_q <= 1'b0;
              paused_q  <= 1'b1;
            end else if (tick_i) begin
              if (terminal) begin
                count_q <= '0;
                done_q  <= 1'b1;
                if (!mode_i) begin
                  state_q   <= IDLE;
                  running_q <= 1'b0;
                end
              end else begin
                count_q <= count_inc[WORD_LENGTH-1:0];
              end
            end
          end
          HOLD: begin
            if (enable_i) begin
              state_q   <= RUN;
              running_q <= 1'b1;
              paused_q  <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign done_o    = done_q;
  assign running_o = running_q;
  assign paused_o  = paused_q;
  assign count_o   = count_q;

endmodule
